logic_unit_acc: RTL and testbench
=================================

LOGIC_UNIT_ACC -- requirements
Module: logic_unit_acc

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set operand and result width in bits (legal range 1 to 64).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the transaction counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: the operand set on A, B, op, acc_mode is valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operand set this cycle.
REQ-008 Port op, input, 3 bits: operation select.
REQ-009 Port acc_mode, input, 1 bit: 0 = two-operand mode; 1 = accumulate mode.
REQ-010 Port A, input, WIDTH bits: first operand.
REQ-011 Port B, input, WIDTH bits: second operand; ignored in accumulate mode.
REQ-012 Port clear, input, 1 bit: synchronous accumulator clear.
REQ-013 Port out_valid, output, 1 bit: Y and the flags hold a valid result.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-015 Port Y, output, WIDTH bits: registered result.
REQ-016 Port Z, output, 1 bit: registered flag, set when Y equals 0.
REQ-017 Port N, output, 1 bit: registered flag, equal to Y[WIDTH-1].
REQ-018 Port P, output, 1 bit: registered flag, equal to the XOR reduction of Y (odd parity).
REQ-019 Port count, output, CNT_W bits: number of accepted transactions, modulo 2^CNT_W.

Function
REQ-020 Op encoding SHALL be bitwise per lane: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT X, 111 pass X.
REQ-021 In acc_mode=0, X SHALL be A, the second operand SHALL be B, and the accumulator SHALL be unchanged.
REQ-022 In acc_mode=1, X SHALL be the accumulator ACC, the second operand SHALL be A, and ACC SHALL load the result on accept.
REQ-023 An operand set SHALL be accepted when in_valid and in_ready are both high on a rising edge.
REQ-024 in_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-025 On accept, Y, Z, N and P SHALL load at that edge, and out_valid SHALL be high from the next cycle (latency 1).
REQ-026 While out_valid is high and out_ready is low, Y, the flags and out_valid SHALL hold stable.
REQ-027 When out_ready is high, out_valid is high and there is no accept, out_valid SHALL clear at the edge.
REQ-028 If a result is consumed and a new set is accepted on the same edge, the new result SHALL load and out_valid SHALL stay high; this gives one result per cycle at full throughput.
REQ-029 When clear is high, ACC SHALL become 0 at the edge, independent of the handshake.
REQ-030 If clear and an accumulate-mode accept coincide, the operation SHALL use 0 as ACC, and ACC SHALL take that result.
REQ-031 clear SHALL NOT affect Y, the flags, out_valid or count.
REQ-032 count SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-033 Input changes without an accept SHALL have no effect on any state.

Reset
REQ-034 While rst is high, ACC, Y and count SHALL be 0; out_valid SHALL be 0; Z SHALL be 1; N and P SHALL be 0. in_ready therefore reads 1.
REQ-035 Reset asserted mid-transaction SHALL discard any pending result, with no output handshake completing.
REQ-036 Reset SHALL take effect without a clock edge; release SHALL be synchronous to clk.

Verification (WIDTH=16, CNT_W=8)
REQ-037 Two-operand: A=0xF0F0, B=0xFF00, op=010, accepted -> next cycle Y=0x0FF0, Z=0, N=0, P=0, out_valid=1.
REQ-038 Accumulate: after clear, send A=0x1234 then A=0x00FF with op=010, acc_mode=1 -> Y=0x1234, then Y=0x12CB; ACC=0x12CB.
REQ-039 Backpressure: hold out_ready=0 for 3 cycles after a result -> in_ready=0, and Y is stable for 3 cycles. With out_ready=1 and in_valid=1 every cycle -> one result per cycle.
REQ-040 Clear collision: ACC=0xAAAA; clear=1 with an accumulate accept, op=001, A=0x0001 -> Y=0x0001, ACC=0x0001.
REQ-041 Counter wrap: 256 accepts from reset -> count=0x00; the 257th accept -> count=0x01.
REQ-042 Async reset: assert rst with out_valid=1 and count=5, between clock edges -> outputs at reset values immediately (Z=1, in_ready=1).

Source files
------------

// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with optional accumulator feedback, valid/ready handshake
// on both sides, registered result flags and an accepted-transaction counter.
module logic_unit_acc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             N,
    output logic             P,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTX = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-edge clear makes the accumulate operation see zero.
    assign acc_eff = clear ? '0 : acc;

    always_comb begin
        x      = acc_mode ? acc_eff : A;
        s      = acc_mode ? A : B;
        result = '0;
        unique case (op_e'(op))
            OP_AND:  result = x & s;
            OP_OR:   result = x | s;
            OP_XOR:  result = x ^ s;
            OP_XNOR: result = ~(x ^ s);
            OP_NAND: result = ~(x & s);
            OP_NOR:  result = ~(x | s);
            OP_NOTX: result = ~x;
            OP_PASS: result = x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && acc_mode) begin
            acc <= result;
        end else if (clear) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            Z         <= 1'b1;
            N         <= 1'b0;
            P         <= 1'b0;
            out_valid <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            Y         <= result;
            Z         <= (result == '0);
            N         <= result[WIDTH-1];
            P         <= ^result;
            out_valid <= 1'b1;
            count     <= count + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed-vector bench for logic_unit_acc (WIDTH=16, CNT_W=8).
module tb_logic_unit_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        acc_mode;
    logic [15:0] A;
    logic [15:0] B;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Y;
    logic        Z;
    logic        N;
    logic        P;
    logic [7:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] table_y [8];

    logic_unit_acc #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_mode  (acc_mode),
        .A         (A),
        .B         (B),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Z         (Z),
        .N         (N),
        .P         (P),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        table_y[0] = 16'hF000; table_y[1] = 16'hFFF0;
        table_y[2] = 16'h0FF0; table_y[3] = 16'hF00F;
        table_y[4] = 16'h0FFF; table_y[5] = 16'h000F;
        table_y[6] = 16'h0F0F; table_y[7] = 16'hF0F0;

        rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0;
        A = '0; B = '0; clear = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_y", Y, 16'h0000);
        check("rst_z", Z, 1);
        check("rst_n", N, 0);
        check("rst_p", P, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Two-operand XOR
        in_valid = 1'b1; A = 16'hF0F0; B = 16'hFF00; op = 3'b010;
        step();
        in_valid = 1'b0;
        check("xor_y", Y, 16'h0FF0);
        check("xor_z", Z, 0);
        check("xor_n", N, 0);
        check("xor_p", P, 0);
        check("xor_out_valid", out_valid, 1);
        check("xor_count", count, 1);
        step();
        check("drain_out_valid", out_valid, 0);

        // Accumulate after clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_only_count", count, 1);
        in_valid = 1'b1; acc_mode = 1'b1; op = 3'b010; A = 16'h1234;
        step();
        check("acc1_y", Y, 16'h1234);
        A = 16'h00FF;
        step();
        check("acc2_y", Y, 16'h12CB);
        check("acc2_p", P, 1);
        check("acc2_out_valid", out_valid, 1);
        op = 3'b111; A = 16'h5555;
        step();
        check("acc_readback", Y, 16'h12CB);
        check("acc_count", count, 4);
        in_valid = 1'b0; acc_mode = 1'b0;
        step();
        check("acc_drain", out_valid, 0);

        // Backpressure: result held, pending set not accepted
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; A = 16'h00FF; B = 16'h0F0F;
        step();
        A = 16'hFFFF; B = 16'h0000; op = 3'b001;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_y", Y, 16'h000F);
            check("bp_out_valid", out_valid, 1);
            step();
        end
        check("bp_count", count, 5);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        step();
        check("bp_or_y", Y, 16'hFFFF);
        check("bp_or_n", N, 1);
        check("bp_or_p", P, 0);
        check("bp_or_count", count, 6);

        // Full-throughput sweep of every op
        A = 16'hF0F0; B = 16'hFF00;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            check("op_table_y", Y, table_y[i]);
            check("op_table_out_valid", out_valid, 1);
        end
        check("op_table_count", count, 14);

        // Clear alone leaves outputs alone
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_keep_y", Y, 16'hF0F0);
        check("clear_keep_valid", out_valid, 1);
        check("clear_keep_count", count, 14);

        // Clear colliding with an accumulate accept
        out_ready = 1'b1; in_valid = 1'b1; acc_mode = 1'b1; op = 3'b001; A = 16'hAAAA;
        step();
        check("load_aaaa", Y, 16'hAAAA);
        clear = 1'b1; A = 16'h0001;
        step();
        clear = 1'b0;
        check("collide_y", Y, 16'h0001);
        op = 3'b111; A = 16'h0000;
        step();
        check("collide_acc", Y, 16'h0001);
        check("collide_count", count, 17);

        // Async reset mid-transaction
        acc_mode = 1'b0; op = 3'b001; A = 16'h8000; B = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        repeat (4) step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("pre_rst_count", count, 5);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_n", N, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_z", Z, 1);
        check("async_in_ready", in_ready, 1);
        check("async_out_valid", out_valid, 0);
        check("async_count", count, 0);
        check("async_y", Y, 16'h0000);
        check("async_n", N, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_valid", out_valid, 0);

        // Counter wrap
        out_ready = 1'b1; in_valid = 1'b1; op = 3'b000;
        repeat (255) step();
        check("count_255", count, 8'hFF);
        step();
        check("count_wrap", count, 8'h00);
        step();
        check("count_257", count, 8'h01);
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
